// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants and types for the 160x120, 3-bit-colour VGA pixel path.
//   - SCREEN_W / SCREEN_H : visible raster size in pixels
//   - X_BITS / Y_BITS     : widths of the vga_adapter x / y inputs
//   - C_BITS              : colour width
//   - CNT_BITS            : width of internal width/height/scan counters;
//                           wide enough to hold a full-screen count of 160
//   - plot_state_t        : plotter FSM state encoding
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_BITS   = 8;
    localparam int Y_BITS   = 7;
    localparam int C_BITS   = 3;
    localparam int CNT_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } plot_state_t;

endpackage

// File: rtl/xy_scan_counter.sv
// ---------------------------------------------------------------------------
// xy_scan_counter
//   Row-major 2-D scan counter over a w x h area. cx advances first; when it
//   reaches w-1 it returns to 0 and cy advances. Written generically so a
//   sprite/ROM blitter can reuse it.
//
//   Ports
//     clk, reset_n : clock, asynchronous active-low reset
//     load         : restart the scan at (0,0) (has priority over step)
//     step         : advance one position in scan order
//     w, h         : area size; must be non-zero while stepping
//     cx, cy       : current scan position
//     cx_next,
//     cy_next      : position one step ahead of (cx,cy), so a client can
//                    register the next pixel's outputs on the same edge
//                    that advances the counter
//     last         : current position is the final one (w-1, h-1)
// ---------------------------------------------------------------------------
module xy_scan_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] w,
    input  logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic [CNT_W-1:0] cx_next,
    output logic [CNT_W-1:0] cy_next,
    output logic             last
);

    logic [CNT_W-1:0] cx_reg;
    logic [CNT_W-1:0] cy_reg;
    logic             row_end;

    assign row_end = (cx_reg == (w - CNT_W'(1)));
    assign last    = row_end && (cy_reg == (h - CNT_W'(1)));

    always_comb begin
        if (row_end) begin
            cx_next = '0;
            cy_next = cy_reg + CNT_W'(1);
        end else begin
            cx_next = cx_reg + CNT_W'(1);
            cy_next = cy_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (load) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (step) begin
            cx_reg <= cx_next;
            cy_reg <= cy_next;
        end
    end

    assign cx = cx_reg;
    assign cy = cy_reg;

endmodule

// File: rtl/box_plotter.sv
// ---------------------------------------------------------------------------
// box_plotter
//   Rasterises one rectangle fill (or a full-screen clear) per request at one
//   pixel per clock, driving the vga_adapter x/y/colour/plot inputs.
//   Off-screen pixels still take their cycle but are not plotted.
//
//   Ports
//     clk, reset_n        : clock, asynchronous active-low reset
//     req_valid/req_ready : request handshake; accepted when both are high
//     req_clear           : 1 = clear the whole screen (x/y/w/h ignored)
//     req_x, req_y        : top-left corner
//     req_w, req_h        : rectangle size (0 on either side = nothing drawn)
//     req_colour          : fill colour
//     pix_x, pix_y,
//     pix_colour, plot    : to vga_adapter
//     busy                : request in progress
//     done                : one-cycle pulse when a request completes
// ---------------------------------------------------------------------------
module box_plotter
    import vga_pkg::*;
#(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int SZ_W     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_clear,
    input  logic [X_BITS-1:0] req_x,
    input  logic [Y_BITS-1:0] req_y,
    input  logic [SZ_W-1:0]   req_w,
    input  logic [SZ_W-1:0]   req_h,
    input  logic [C_BITS-1:0] req_colour,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    output logic [C_BITS-1:0] pix_colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    // ---------------------------------------------------------------------
    // State and latched request
    // ---------------------------------------------------------------------
    plot_state_t         state_reg;
    logic [X_BITS-1:0]   x0_reg;
    logic [Y_BITS-1:0]   y0_reg;
    logic [CNT_BITS-1:0] w_reg;
    logic [CNT_BITS-1:0] h_reg;
    logic [C_BITS-1:0]   colour_reg;

    logic [X_BITS-1:0]   pix_x_reg;
    logic [Y_BITS-1:0]   pix_y_reg;
    logic [C_BITS-1:0]   pix_colour_reg;
    logic                plot_reg;
    logic                done_reg;

    // ---------------------------------------------------------------------
    // Request decode: a clear is just a full-screen rectangle from (0,0)
    // ---------------------------------------------------------------------
    logic                accept;
    logic [X_BITS-1:0]   lat_x;
    logic [Y_BITS-1:0]   lat_y;
    logic [CNT_BITS-1:0] lat_w;
    logic [CNT_BITS-1:0] lat_h;
    logic                lat_empty;

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        if (req_clear) begin
            lat_x = '0;
            lat_y = '0;
            lat_w = CNT_BITS'(SCREEN_W);
            lat_h = CNT_BITS'(SCREEN_H);
        end else begin
            lat_x = req_x;
            lat_y = req_y;
            lat_w = CNT_BITS'(req_w);
            lat_h = CNT_BITS'(req_h);
        end
    end

    assign lat_empty = (lat_w == '0) || (lat_h == '0);

    // ---------------------------------------------------------------------
    // Scan counter. Its state tracks the pixel currently on the outputs;
    // the look-ahead position feeds the output registers so each edge both
    // advances the scan and presents the matching pixel.
    // ---------------------------------------------------------------------
    logic                scan_step;
    logic                scan_last;
    logic [CNT_BITS-1:0] cx;
    logic [CNT_BITS-1:0] cy;
    logic [CNT_BITS-1:0] cx_next;
    logic [CNT_BITS-1:0] cy_next;
    logic                scan_pos_unused;

    assign scan_step = (state_reg == DRAW) && !scan_last;

    xy_scan_counter #(
        .CNT_W (CNT_BITS)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .step    (scan_step),
        .w       (w_reg),
        .h       (h_reg),
        .cx      (cx),
        .cy      (cy),
        .cx_next (cx_next),
        .cy_next (cy_next),
        .last    (scan_last)
    );

    // The plotter only needs the look-ahead position; the current position
    // is there for blitters that index a sprite ROM with it.
    assign scan_pos_unused = ^{cx, cy};

    // ---------------------------------------------------------------------
    // Next pixel coordinate, one bit wider than the screen coordinate so an
    // off-screen pixel is clipped by compare and never wraps back on screen.
    // In IDLE the "next" pixel is the origin of the incoming request.
    // ---------------------------------------------------------------------
    logic [X_BITS:0] sx_next;
    logic [Y_BITS:0] sy_next;
    logic            pix_on_next;

    always_comb begin
        if (state_reg == IDLE) begin
            sx_next = (X_BITS+1)'(lat_x);
            sy_next = (Y_BITS+1)'(lat_y);
        end else begin
            sx_next = (X_BITS+1)'(x0_reg) + (X_BITS+1)'(cx_next);
            sy_next = (Y_BITS+1)'(y0_reg) + (Y_BITS+1)'(cy_next);
        end
    end

    assign pix_on_next = (sx_next < (X_BITS+1)'(SCREEN_W)) &&
                         (sy_next < (Y_BITS+1)'(SCREEN_H));

    // ---------------------------------------------------------------------
    // Plotter FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            x0_reg         <= '0;
            y0_reg         <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            colour_reg     <= '0;
            pix_x_reg      <= '0;
            pix_y_reg      <= '0;
            pix_colour_reg <= '0;
            plot_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            plot_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x0_reg     <= lat_x;
                        y0_reg     <= lat_y;
                        w_reg      <= lat_w;
                        h_reg      <= lat_h;
                        colour_reg <= req_colour;
                        if (lat_empty) begin
                            // Nothing to draw: complete straight away.
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg      <= DRAW;
                            pix_x_reg      <= sx_next[X_BITS-1:0];
                            pix_y_reg      <= sy_next[Y_BITS-1:0];
                            pix_colour_reg <= req_colour;
                            plot_reg       <= pix_on_next;
                        end
                    end
                end
                DRAW: begin
                    if (scan_last) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        pix_x_reg      <= sx_next[X_BITS-1:0];
                        pix_y_reg      <= sy_next[Y_BITS-1:0];
                        pix_colour_reg <= colour_reg;
                        plot_reg       <= pix_on_next;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pix_x      = pix_x_reg;
    assign pix_y      = pix_y_reg;
    assign pix_colour = pix_colour_reg;
    assign plot       = plot_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_box_plotter.sv
// ---------------------------------------------------------------------------
// tb_box_plotter
//   Directed and randomized requests against box_plotter. Expected pixels are
//   produced by a simple nested-loop raster model of each request.
// ---------------------------------------------------------------------------
module tb_box_plotter;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic       req_valid  = 1'b0;
    logic       req_clear  = 1'b0;
    logic [7:0] req_x      = '0;
    logic [6:0] req_y      = '0;
    logic [4:0] req_w      = '0;
    logic [4:0] req_h      = '0;
    logic [2:0] req_colour = '0;
    logic       req_ready;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    // Optional follow-on request, presented right after the current one is
    // accepted while req_valid stays high.
    bit         hold_next = 1'b0;
    logic       n_clr;
    logic [7:0] n_x;
    logic [6:0] n_y;
    logic [4:0] n_w;
    logic [4:0] n_h;
    logic [2:0] n_c;

    box_plotter #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .SZ_W     (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_clear  (req_clear),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic present(input logic clr, input logic [7:0] x, input logic [6:0] y,
                           input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
        req_clear  = clr;
        req_x      = x;
        req_y      = y;
        req_w      = w;
        req_h      = h;
        req_colour = c;
        req_valid  = 1'b1;
    endtask

    // Called in the cycle where the request is on the inputs. Returns in the
    // first IDLE cycle after the done pulse.
    task automatic expect_req(input logic clr, input logic [7:0] x, input logic [6:0] y,
                              input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
        int x0;
        int y0;
        int ww;
        int hh;
        int ex;
        int ey;
        bit ep;
        int n_exp;
        int n_got;
        int guard;
        if (clr) begin
            x0 = 0;   y0 = 0;   ww = 160; hh = 120;
        end else begin
            x0 = int'(x); y0 = int'(y); ww = int'(w); hh = int'(h);
        end
        guard = 0;
        while (!req_ready && guard < 64) begin
            tick();
            guard++;
        end
        check("ready_at_accept", 32'(req_ready), 32'd1);
        tick();
        if (hold_next) begin
            present(n_clr, n_x, n_y, n_w, n_h, n_c);
            hold_next = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        n_exp = 0;
        n_got = 0;
        for (int j = 0; j < hh; j++) begin
            for (int i = 0; i < ww; i++) begin
                ex = x0 + i;
                ey = y0 + j;
                ep = (ex < 160) && (ey < 120);
                check("plot", 32'(plot), 32'(ep));
                check("pix_x", 32'(pix_x), 32'(ex & 255));
                check("pix_y", 32'(pix_y), 32'(ey & 127));
                check("pix_colour", 32'(pix_colour), 32'(c));
                if (i == 0 && j == 0) begin
                    check("busy_draw", 32'(busy), 32'd1);
                    check("ready_draw", 32'(req_ready), 32'd0);
                end
                if (ep) n_exp++;
                if (plot === 1'b1) n_got++;
                tick();
            end
        end
        check("plot_count", 32'(n_got), 32'(n_exp));
        check("done_pulse", 32'(done), 32'd1);
        check("plot_in_fin", 32'(plot), 32'd0);
        check("ready_in_fin", 32'(req_ready), 32'd0);
        check("busy_in_fin", 32'(busy), 32'd1);
        tick();
        check("done_cleared", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("ready_idle", 32'(req_ready), 32'd1);
        check("plot_idle", 32'(plot), 32'd0);
        $display("req clr=%0d x=%0d y=%0d w=%0d h=%0d c=%0d: %0d plots expected, %0d seen",
                 clr, x, y, w, h, c, n_exp, n_got);
    endtask

    initial begin
        logic [7:0] rx;
        logic [6:0] ry;
        logic [4:0] rw;
        logic [4:0] rh;
        logic [2:0] rc;

        // Reset values
        #1 reset_n = 1'b0;
        #1;
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_pix_y", 32'(pix_y), 32'd0);
        check("rst_colour", 32'(pix_colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // 2x2 box, then outputs hold their last pixel in IDLE
        present(1'b0, 8'd10, 7'd20, 5'd2, 5'd2, 3'd3);
        expect_req(1'b0, 8'd10, 7'd20, 5'd2, 5'd2, 3'd3);
        check("idle_hold_x", 32'(pix_x), 32'd11);
        check("idle_hold_y", 32'(pix_y), 32'd21);
        check("idle_hold_c", 32'(pix_colour), 32'd3);

        // Clipping at the bottom-right corner
        present(1'b0, 8'd158, 7'd119, 5'd4, 5'd2, 3'd6);
        expect_req(1'b0, 8'd158, 7'd119, 5'd4, 5'd2, 3'd6);

        // Zero width
        present(1'b0, 8'd40, 7'd40, 5'd0, 5'd5, 3'd1);
        expect_req(1'b0, 8'd40, 7'd40, 5'd0, 5'd5, 3'd1);

        // Zero height
        present(1'b0, 8'd40, 7'd40, 5'd7, 5'd0, 3'd2);
        expect_req(1'b0, 8'd40, 7'd40, 5'd7, 5'd0, 3'd2);

        // Full-screen clear with garbage geometry
        present(1'b1, 8'd200, 7'd100, 5'd7, 5'd0, 3'd0);
        expect_req(1'b1, 8'd200, 7'd100, 5'd7, 5'd0, 3'd0);

        // Back-to-back: fields change mid-DRAW while req_valid stays high
        n_clr = 1'b0; n_x = 8'd50; n_y = 7'd60; n_w = 5'd2; n_h = 5'd3; n_c = 3'd6;
        hold_next = 1'b1;
        present(1'b0, 8'd30, 7'd40, 5'd3, 5'd2, 3'd5);
        expect_req(1'b0, 8'd30, 7'd40, 5'd3, 5'd2, 3'd5);
        check("b2b_valid_held", 32'(req_valid), 32'd1);
        expect_req(1'b0, 8'd50, 7'd60, 5'd2, 5'd3, 3'd6);

        // Reset in the middle of a 16x16 draw
        present(1'b0, 8'd5, 7'd5, 5'd16, 5'd16, 3'd2);
        check("rst_test_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rst_test_plot", 32'(plot), 32'd1);
            check("rst_test_x", 32'(pix_x), 32'(5 + k));
            tick();
        end
        #3 reset_n = 1'b0;
        #1;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_plot", 32'(plot), 32'd0);
        end
        $display("reset during 16x16 draw: outputs dropped");
        present(1'b0, 8'd3, 7'd4, 5'd1, 5'd1, 3'd7);
        expect_req(1'b0, 8'd3, 7'd4, 5'd1, 5'd1, 3'd7);

        // Randomized requests, biased toward the right/bottom screen edges
        for (int k = 0; k < 12; k++) begin
            rx = 8'($urandom_range(0, 175));
            ry = 7'($urandom_range(0, 127));
            rw = 5'($urandom_range(0, 31));
            rh = 5'($urandom_range(0, 31));
            rc = 3'($urandom_range(0, 7));
            present(1'b0, rx, ry, rw, rh, rc);
            expect_req(1'b0, rx, ry, rw, rh, rc);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
